mc_control_fsm: RTL and testbench

//  Parametrised multicycle control unit: owns the state register, decodes the latched IR
//  and drives all datapath mux selects/enables.

---
 rtl/mc_control_fsm_if.sv | 55 +++++
 rtl/mc_control_fsm.sv | 199 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Control-unit bundle between the multicycle datapath and mc_control_fsm.
// Carries IR/flags into the controller and every mux select/enable out of it.
// Optional macro MC_MEM_WAIT_EN adds the mem_ready input from memory.
// Handshake: mem_ready is sampled on posedge clk while a memory strobe
// (mem_rd/mem_wr) is high; the strobe and state hold until mem_ready=1 is seen.
interface mc_control_fsm_if #(
    parameter int IW   = 16,
    parameter int NREG = 8,
    parameter int RAW  = 3
);
    logic [IW-1:0]  ir;
    logic           flag_c;
    logic           flag_z;
`ifdef MC_MEM_WAIT_EN
    logic           mem_ready;
`endif
    logic [3:0]     state;
    logic           ir_we;
    logic           pc_we;
    logic           mem_rd;
    logic           mem_wr;
    logic           rf_we;
    logic [1:0]     rf_wsel;
    logic [1:0]     rf_dsel;
    logic [1:0]     alu_a_sel;
    logic [1:0]     alu_b_sel;
    logic [1:0]     alu_op;
    logic           cz_en;
    logic [RAW-1:0] lmsm_idx;
    logic           illegal;

`ifdef MC_MEM_WAIT_EN
    modport master (
        input  ir, flag_c, flag_z, mem_ready,
        output state, ir_we, pc_we, mem_rd, mem_wr, rf_we, rf_wsel, rf_dsel,
               alu_a_sel, alu_b_sel, alu_op, cz_en, lmsm_idx, illegal
    );
    modport slave (
        output ir, flag_c, flag_z, mem_ready,
        input  state, ir_we, pc_we, mem_rd, mem_wr, rf_we, rf_wsel, rf_dsel,
               alu_a_sel, alu_b_sel, alu_op, cz_en, lmsm_idx, illegal
    );
`else
    modport master (
        input  ir, flag_c, flag_z,
        output state, ir_we, pc_we, mem_rd, mem_wr, rf_we, rf_wsel, rf_dsel,
               alu_a_sel, alu_b_sel, alu_op, cz_en, lmsm_idx, illegal
    );
    modport slave (
        output ir, flag_c, flag_z,
        input  state, ir_we, pc_we, mem_rd, mem_wr, rf_we, rf_wsel, rf_dsel,
               alu_a_sel, alu_b_sel, alu_op, cz_en, lmsm_idx, illegal
    );
`endif
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: state register, IR decode and all datapath selects.
// Supports conditional ADD/NAND, LM/SM register sequencing and an illegal-opcode trap.
// Optional macro MC_MEM_WAIT_EN: memory states wait for mem_ready before advancing.
// Outputs are registered: each cycle the decode of the *next* state/index is loaded,
// so the output registers always reflect the current state (Moore behaviour).
// BEQ takes flag_z, as seen while in DECODE, as its equality indication.
module mc_control_fsm #(
    parameter int IW   = 16,
    parameter int NREG = 8,
    parameter int RAW  = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    mc_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_WB     = 4'd4,
        S_ADDR   = 4'd5,
        S_MRD    = 4'd6,
        S_MWR    = 4'd7,
        S_BR     = 4'd8,
        S_LMSM   = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADI  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LHI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_LM   = 4'b0110;
    localparam logic [3:0] OP_SM   = 4'b0111;
    localparam logic [3:0] OP_JAL  = 4'b1000;
    localparam logic [3:0] OP_JLR  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1100;

    state_t         r_state;
    logic [RAW-1:0] r_idx;
    logic           r_ir_we, r_pc_we, r_mem_rd, r_mem_wr, r_rf_we, r_cz_en, r_illegal;
    logic [1:0]     r_rf_wsel, r_rf_dsel, r_alu_a_sel, r_alu_b_sel, r_alu_op;

    state_t         w_nxt_state;
    logic [RAW-1:0] w_nxt_idx;
    logic           w_ir_we, w_pc_we, w_mem_rd, w_mem_wr, w_rf_we, w_cz_en, w_illegal;
    logic [1:0]     w_rf_wsel, w_rf_dsel, w_alu_a_sel, w_alu_b_sel, w_alu_op;

    logic [3:0]      w_opcode;
    logic [NREG-1:0] w_mask;
    logic            w_cond_ok;
    logic            w_mem_ok;
    logic            w_last;

    assign w_opcode = bus.ir[IW-1:IW-4];
    assign w_mask   = bus.ir[NREG-1:0];
    assign w_last   = (r_idx == RAW'(NREG - 1));
    // ir[1:0]=10 gates on carry, 01 gates on zero; other codes always execute
    assign w_cond_ok = !((bus.ir[1:0] == 2'b10 && !bus.flag_c) ||
                         (bus.ir[1:0] == 2'b01 && !bus.flag_z));
`ifdef MC_MEM_WAIT_EN
    assign w_mem_ok = bus.mem_ready;
`else
    assign w_mem_ok = 1'b1;
`endif

    // Next state and LM/SM index sequencing
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        case (r_state)
            S_IDLE:   w_nxt_state = S_FETCH;
            S_FETCH:  if (w_mem_ok) w_nxt_state = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_ADD, OP_NAND: w_nxt_state = w_cond_ok ? S_EXEC : S_FETCH;
                    OP_ADI:          w_nxt_state = S_EXEC;
                    OP_LHI:          w_nxt_state = S_WB;
                    OP_LW, OP_SW:    w_nxt_state = S_ADDR;
                    OP_LM, OP_SM:    w_nxt_state = S_LMSM;
                    OP_BEQ, OP_JAL, OP_JLR: w_nxt_state = S_BR;
                    default:         w_nxt_state = S_TRAP;
                endcase
            end
            S_EXEC:   w_nxt_state = S_WB;
            S_WB:     w_nxt_state = S_FETCH;
            S_ADDR:   w_nxt_state = (w_opcode == OP_SW) ? S_MWR : S_MRD;
            S_MRD:    if (w_mem_ok) w_nxt_state = S_WB;
            S_MWR:    if (w_mem_ok) w_nxt_state = S_FETCH;
            S_BR:     w_nxt_state = S_FETCH;
            S_LMSM: begin
                // clear mask bits never wait; set bits wait for the memory
                if (!w_mask[r_idx] || w_mem_ok) begin
                    if (w_last) begin
                        w_nxt_state = S_FETCH;
                        w_nxt_idx   = '0;
                    end else begin
                        w_nxt_idx   = r_idx + RAW'(1);
                    end
                end
            end
            S_TRAP:   w_nxt_state = S_FETCH;
            default:  begin
                w_nxt_state = S_IDLE;
                w_nxt_idx   = '0;
            end
        endcase
    end

    // Output decode for the state being entered next cycle
    always_comb begin
        w_ir_we = 1'b0; w_pc_we = 1'b0; w_mem_rd = 1'b0; w_mem_wr = 1'b0;
        w_rf_we = 1'b0; w_cz_en = 1'b0; w_illegal = 1'b0;
        w_rf_wsel = 2'd0; w_rf_dsel = 2'd0;
        w_alu_a_sel = 2'd0; w_alu_b_sel = 2'd0; w_alu_op = 2'd0;
        case (w_nxt_state)
            S_FETCH: begin
                w_mem_rd = 1'b1; w_ir_we = 1'b1; w_pc_we = 1'b1;
                w_alu_b_sel = 2'd1;
            end
            S_EXEC: begin
                w_cz_en     = 1'b1;
                w_alu_a_sel = 2'd1;
                w_alu_b_sel = (w_opcode == OP_ADI) ? 2'd2 : 2'd0;
                w_alu_op    = (w_opcode == OP_NAND) ? 2'd1 : 2'd0;
            end
            S_WB: begin
                w_rf_we = 1'b1;
                if (w_opcode == OP_ADD || w_opcode == OP_NAND) w_rf_wsel = 2'd2;
                else if (w_opcode == OP_ADI)                   w_rf_wsel = 2'd1;
                if (w_opcode == OP_LHI)     w_rf_dsel = 2'd2;
                else if (w_opcode == OP_LW) w_rf_dsel = 2'd1;
            end
            S_ADDR: begin
                w_alu_a_sel = 2'd1; w_alu_b_sel = 2'd2;
            end
            S_MRD: w_mem_rd = 1'b1;
            S_MWR: w_mem_wr = 1'b1;
            S_BR: begin
                if (w_opcode == OP_BEQ) begin
                    w_alu_a_sel = 2'd1; w_alu_op = 2'd2;
                    w_pc_we     = bus.flag_z;
                end else begin
                    w_pc_we = 1'b1; w_rf_we = 1'b1; w_rf_dsel = 2'd3;
                    if (w_opcode == OP_JAL) w_alu_b_sel = 2'd3;
                end
            end
            S_LMSM: begin
                if (w_mask[w_nxt_idx]) begin
                    // T1 <- T1 + 1 alongside each transfer
                    w_alu_a_sel = 2'd2; w_alu_b_sel = 2'd1;
                    if (w_opcode == OP_LM) begin
                        w_mem_rd = 1'b1; w_rf_we = 1'b1;
                        w_rf_wsel = 2'd3; w_rf_dsel = 2'd1;
                    end else begin
                        w_mem_wr = 1'b1;
                    end
                end
            end
            S_TRAP:  w_illegal = 1'b1;
            default: ;
        endcase
    end

    // State, index and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE; r_idx <= '0;
            r_ir_we <= 1'b0; r_pc_we <= 1'b0; r_mem_rd <= 1'b0; r_mem_wr <= 1'b0;
            r_rf_we <= 1'b0; r_cz_en <= 1'b0; r_illegal <= 1'b0;
            r_rf_wsel <= 2'd0; r_rf_dsel <= 2'd0;
            r_alu_a_sel <= 2'd0; r_alu_b_sel <= 2'd0; r_alu_op <= 2'd0;
        end else begin
            r_state <= w_nxt_state; r_idx <= w_nxt_idx;
            r_ir_we <= w_ir_we; r_pc_we <= w_pc_we; r_mem_rd <= w_mem_rd; r_mem_wr <= w_mem_wr;
            r_rf_we <= w_rf_we; r_cz_en <= w_cz_en; r_illegal <= w_illegal;
            r_rf_wsel <= w_rf_wsel; r_rf_dsel <= w_rf_dsel;
            r_alu_a_sel <= w_alu_a_sel; r_alu_b_sel <= w_alu_b_sel; r_alu_op <= w_alu_op;
        end
    end

    assign bus.state     = r_state;
    assign bus.lmsm_idx  = r_idx;
    assign bus.ir_we     = r_ir_we;
    assign bus.pc_we     = r_pc_we;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.rf_we     = r_rf_we;
    assign bus.rf_wsel   = r_rf_wsel;
    assign bus.rf_dsel   = r_rf_dsel;
    assign bus.alu_a_sel = r_alu_a_sel;
    assign bus.alu_b_sel = r_alu_b_sel;
    assign bus.alu_op    = r_alu_op;
    assign bus.cz_en     = r_cz_en;
    assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed scenarios plus a random instruction stream.
// Expected per-cycle output vectors come from an instruction-level model.
module tb_mc_control_fsm;
  localparam int IW = 16;
  localparam int NREG = 8;
  localparam int RAW = 3;
  localparam int W = 24;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.IW(IW), .NREG(NREG), .RAW(RAW)) bus ();
  mc_control_fsm #(.IW(IW), .NREG(NREG), .RAW(RAW)) dut (
    .i_clk(clk), .i_reset(reset), .bus(bus)
  );

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int stall_left = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {state, ir_we, pc_we, mem_rd, mem_wr, rf_we, wsel, dsel, a, b, op, cz, idx, illegal}
  function automatic logic [W-1:0] mk(input int st, input bit irw, input bit pcw,
      input bit mrd, input bit mwr, input bit rfw, input int ws, input int ds,
      input int a, input int b, input int op, input bit cz, input int idx, input bit ill);
    return {4'(st), irw, pcw, mrd, mwr, rfw, 2'(ws), 2'(ds), 2'(a), 2'(b), 2'(op),
            cz, 3'(idx), ill};
  endfunction

  function automatic logic [W-1:0] obs();
    return {bus.state, bus.ir_we, bus.pc_we, bus.mem_rd, bus.mem_wr, bus.rf_we,
            bus.rf_wsel, bus.rf_dsel, bus.alu_a_sel, bus.alu_b_sel, bus.alu_op,
            bus.cz_en, bus.lmsm_idx, bus.illegal};
  endfunction

  // Instruction-level reference: cycle-by-cycle outputs for one instruction
  task automatic model_push(input logic [15:0] ir, input bit c, input bit z, input int stall);
    logic [3:0] opc;
    bit run;
    opc = ir[15:12];
    exp_q.push_back(mk(1, 1,1,1,0,0, 0,0, 0,1,0, 0, 0,0));
    exp_q.push_back(mk(2, 0,0,0,0,0, 0,0, 0,0,0, 0, 0,0));
    case (opc)
      4'h0, 4'h2: begin
        run = 1'b1;
        if (ir[1:0] == 2'b10 && !c) run = 1'b0;
        if (ir[1:0] == 2'b01 && !z) run = 1'b0;
        if (run) begin
          exp_q.push_back(mk(3, 0,0,0,0,0, 0,0, 1,0,(opc == 4'h2) ? 1 : 0, 1, 0,0));
          exp_q.push_back(mk(4, 0,0,0,0,1, 2,0, 0,0,0, 0, 0,0));
        end
      end
      4'h1: begin
        exp_q.push_back(mk(3, 0,0,0,0,0, 0,0, 1,2,0, 1, 0,0));
        exp_q.push_back(mk(4, 0,0,0,0,1, 1,0, 0,0,0, 0, 0,0));
      end
      4'h3: exp_q.push_back(mk(4, 0,0,0,0,1, 0,2, 0,0,0, 0, 0,0));
      4'h4: begin
        exp_q.push_back(mk(5, 0,0,0,0,0, 0,0, 1,2,0, 0, 0,0));
        repeat (stall + 1) exp_q.push_back(mk(6, 0,0,1,0,0, 0,0, 0,0,0, 0, 0,0));
        exp_q.push_back(mk(4, 0,0,0,0,1, 0,1, 0,0,0, 0, 0,0));
      end
      4'h5: begin
        exp_q.push_back(mk(5, 0,0,0,0,0, 0,0, 1,2,0, 0, 0,0));
        exp_q.push_back(mk(7, 0,0,0,1,0, 0,0, 0,0,0, 0, 0,0));
      end
      4'h6, 4'h7: begin
        for (int i = 0; i < NREG; i++) begin
          if (!ir[i])            exp_q.push_back(mk(9, 0,0,0,0,0, 0,0, 0,0,0, 0, i,0));
          else if (opc == 4'h6)  exp_q.push_back(mk(9, 0,0,1,0,1, 3,1, 2,1,0, 0, i,0));
          else                   exp_q.push_back(mk(9, 0,0,0,1,0, 0,0, 2,1,0, 0, i,0));
        end
      end
      4'hC: exp_q.push_back(mk(8, 0,z,0,0,0, 0,0, 1,0,2, 0, 0,0));
      4'h8: exp_q.push_back(mk(8, 0,1,0,0,1, 0,3, 0,3,0, 0, 0,0));
      4'h9: exp_q.push_back(mk(8, 0,1,0,0,1, 0,3, 0,0,0, 0, 0,0));
      default: exp_q.push_back(mk(10, 0,0,0,0,0, 0,0, 0,0,0, 0, 0,1));
    endcase
  endtask

  // Driver: called at the negedge of the first FETCH cycle; max_cyc<0 runs to completion
  // and returns at the negedge of the following FETCH.
  task automatic run_instr(input logic [15:0] ir, input bit c, input bit z,
                           input int stall, input int max_cyc);
    int n;
    bus.ir = ir; bus.flag_c = c; bus.flag_z = z;
    stall_left = stall;
    model_push(ir, c, z, stall);
    n = 0;
    while (exp_q.size() > 0) begin
`ifdef MC_MEM_WAIT_EN
      if (bus.state == 4'd6 && stall_left > 0) begin
        bus.mem_ready = 1'b0;
        stall_left--;
      end else begin
        bus.mem_ready = 1'b1;
      end
`endif
      check($sformatf("ir=%h cyc=%0d", ir, n), obs(), exp_q.pop_front());
      n++;
      if (max_cyc >= 0 && n == max_cyc) break;
      @(negedge clk);
    end
  endtask

  // Two reset cycles, then the first FETCH
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("reset_cyc1", obs(), '0);
    @(negedge clk);
    check("reset_cyc2", obs(), '0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_fetch", obs(), mk(1, 1,1,1,0,0, 0,0, 0,1,0, 0, 0,0));
  endtask

  initial begin
    logic [3:0] opc;
    int stall;
    bus.ir = '0; bus.flag_c = 1'b0; bus.flag_z = 1'b0;
`ifdef MC_MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
    do_reset();
    run_instr(16'h0298, 1'b0, 1'b0, 0, -1);   // ADD, unconditional
    run_instr(16'h029A, 1'b0, 1'b1, 0, -1);   // ADC with C=0: retired in DECODE
    run_instr(16'h029A, 1'b1, 1'b0, 0, -1);   // ADC with C=1: executes
    run_instr(16'h2299, 1'b1, 1'b1, 0, -1);   // NDZ with Z=1
    run_instr(16'h6081, 1'b0, 1'b0, 0, -1);   // LM, mask bits 0 and 7
    run_instr(16'h7000, 1'b0, 1'b0, 0, -1);   // SM, empty mask
    run_instr(16'hF000, 1'b0, 1'b0, 0, -1);   // illegal opcode
    run_instr(16'hC000, 1'b0, 1'b0, 0, -1);   // BEQ not equal
    run_instr(16'hC000, 1'b0, 1'b1, 0, -1);   // BEQ equal
`ifdef MC_MEM_WAIT_EN
    run_instr(16'h4000, 1'b0, 1'b0, 3, -1);   // LW with 3 wait cycles in MRD
`endif
    // reset in the middle of LM at idx 3 (FETCH, DECODE, idx 0..3)
    run_instr(16'h60FF, 1'b0, 1'b0, 0, 6);
    exp_q.delete();
    do_reset();
    // random instruction stream
    for (int k = 0; k < 200; k++) begin
      opc = 4'($urandom_range(0, 15));
      stall = 0;
`ifdef MC_MEM_WAIT_EN
      if (opc == 4'h4) stall = $urandom_range(0, 3);
`endif
      run_instr({opc, 12'($urandom)}, 1'($urandom), 1'($urandom), stall, -1);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
